// File: rtl/lut_truth_table_dumper.sv
`default_nettype none
// ============================================================================
// Module   : lut_truth_table_dumper
// Purpose  : Sweeps every input code of a combinational neuron ROM, packs the
//            outputs LSB-first into words and streams them on valid/ready.
// Revision : 1.0
// ============================================================================
module lut_truth_table_dumper #(
    parameter int IN_BITS   = 6,
    parameter int OUT_BITS  = 1,
    parameter int WORD_BITS = 8,
    parameter int LUT_LAT   = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    output logic                 busy,
    output logic                 done,
    output logic [IN_BITS-1:0]   lut_in,
    input  logic [OUT_BITS-1:0]  lut_out,
    output logic [WORD_BITS-1:0] m_data,
    output logic                 m_valid,
    input  logic                 m_ready
);

    localparam int c_addr_w = IN_BITS + 1;
    localparam int c_epw    = WORD_BITS / OUT_BITS;
    localparam int c_slot_w = (c_epw > 1) ? $clog2(c_epw) : 1;
    localparam logic [c_addr_w-1:0] c_last_addr = c_addr_w'((1 << IN_BITS) - 1);
    localparam logic [c_slot_w-1:0] c_last_slot = c_slot_w'(c_epw - 1);
    localparam logic [3:0]          c_lat       = 4'(LUT_LAT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SWEEP = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [c_addr_w-1:0]   r_addr;
    logic [3:0]            r_wait;
    logic [c_slot_w-1:0]   r_slot;
    logic [WORD_BITS-1:0]  r_pack;
    logic [WORD_BITS-1:0]  w_pack_next;
    logic [WORD_BITS-1:0]  r_data;
    logic                  r_full;
    logic                  r_valid;
    logic                  r_done;
    logic                  w_xfer;
    logic                  w_advance;
    logic                  w_sample;
    logic                  w_finish;

    // A completed pack word moves to the output slot when that slot is empty
    // or being emptied this cycle; the sweep may only run while the pack
    // register has room for the next sample.
    assign w_xfer    = r_full && (!r_valid || m_ready);
    assign w_advance = !r_full || w_xfer;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_sample     = 1'b0;
        w_finish     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start && !abort) begin
                    w_state_next = S_SWEEP;
                end
            end
            S_SWEEP: begin
                if (abort) begin
                    w_state_next = S_IDLE;
                end else if (w_advance && (r_wait == 4'd0)) begin
                    w_sample = 1'b1;
                    if (r_addr == c_last_addr) begin
                        w_state_next = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (abort) begin
                    w_state_next = S_IDLE;
                end else if (!r_full && !r_valid) begin
                    w_finish     = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Slot 0 starts a fresh word, so stale bits of the previous word vanish.
    always_comb begin
        w_pack_next = (r_slot == '0) ? '0 : r_pack;
        w_pack_next[int'(r_slot)*OUT_BITS +: OUT_BITS] = lut_out;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr  <= '0;
            r_wait  <= c_lat;
            r_slot  <= '0;
            r_pack  <= '0;
            r_full  <= 1'b0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
        end else if (abort) begin
            r_addr  <= '0;
            r_wait  <= c_lat;
            r_slot  <= '0;
            r_pack  <= '0;
            r_full  <= 1'b0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= w_finish;

            if (r_state == S_IDLE && start) begin
                r_addr <= '0;
                r_wait <= c_lat;
                r_slot <= '0;
            end

            if (w_xfer) begin
                r_data  <= r_pack;
                r_valid <= 1'b1;
                r_full  <= 1'b0;
            end else if (r_valid && m_ready) begin
                r_valid <= 1'b0;
            end

            if (r_state == S_SWEEP && w_advance) begin
                if (r_wait != 4'd0) begin
                    r_wait <= r_wait - 4'd1;
                end else begin
                    r_wait <= c_lat;
                    r_pack <= w_pack_next;
                    if (r_slot == c_last_slot) begin
                        r_slot <= '0;
                        r_full <= 1'b1;
                    end else begin
                        r_slot <= r_slot + c_slot_w'(1);
                    end
                    if (r_addr != c_last_addr) begin
                        r_addr <= r_addr + c_addr_w'(1);
                    end
                end
            end

            if (w_finish) begin
                r_addr <= '0;
            end
        end
    end

    assign busy    = (r_state != S_IDLE);
    assign done    = r_done;
    assign lut_in  = r_addr[IN_BITS-1:0];
    assign m_data  = r_data;
    assign m_valid = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_lut_truth_table_dumper.sv
`default_nettype none
// ============================================================================
// Module   : tb_lut_truth_table_dumper
// Purpose  : Scoreboard bench for the truth-table dumper (LUT_LAT 0 and 2).
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_lut_truth_table_dumper;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Instance 0: defaults, f = in[0] & in[2] & ~in[3]
    logic       start0 = 1'b0, abort0 = 1'b0, ready0 = 1'b1;
    logic       busy0, done0, valid0, lut_out0;
    logic [5:0] lut_in0;
    logic [7:0] data0;
    assign lut_out0 = lut_in0[0] & lut_in0[2] & ~lut_in0[3];

    lut_truth_table_dumper dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0),
        .busy(busy0), .done(done0), .lut_in(lut_in0), .lut_out(lut_out0),
        .m_data(data0), .m_valid(valid0), .m_ready(ready0)
    );

    // Instance 1: LUT_LAT=2, parity neuron behind two register stages
    logic       start1 = 1'b0, abort1 = 1'b0, ready1 = 1'b1;
    logic       busy1, done1, valid1;
    logic [5:0] lut_in1;
    logic [7:0] data1;
    logic       par_s1 = 1'b0, par_s2 = 1'b0;
    always @(posedge clk) begin
        par_s1 <= ^lut_in1;
        par_s2 <= par_s1;
    end

    lut_truth_table_dumper #(.LUT_LAT(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1),
        .busy(busy1), .done(done1), .lut_in(lut_in1), .lut_out(par_s2),
        .m_data(data1), .m_valid(valid1), .m_ready(ready1)
    );

    logic [7:0] exp0[$];
    logic [7:0] exp1[$];
    int acc0 = 0, done_cnt0 = 0, done_cyc0 = 0, start_cyc0 = 0;
    int done_cnt1 = 0, done_cyc1 = 0, start_cyc1 = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor / scoreboard for instance 0
    initial begin
        logic [7:0] e;
        logic [7:0] prev_data;
        logic [5:0] prev_lut;
        bit         prev_stall = 0;
        bit         prev_busy  = 0;
        prev_data = '0;
        prev_lut  = '0;
        forever begin
            @(negedge clk); #2;
            if (!rst_n) begin
                prev_stall = 0;
                prev_busy  = 0;
            end else begin
                if (prev_stall) begin
                    check("stall_valid0", {31'd0, valid0}, 32'd1);
                    check("stall_data0", {24'd0, data0}, {24'd0, prev_data});
                end
                if (valid0 && ready0) begin
                    if (exp0.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_word0: got %0h, expected no word", data0);
                    end else begin
                        e = exp0.pop_front();
                        check("word0", {24'd0, data0}, {24'd0, e});
                    end
                    acc0++;
                end
                prev_stall = valid0 && !ready0;
                prev_data  = data0;
                if (busy0 && prev_busy && lut_in0 != prev_lut)
                    check("lut_step0", {26'd0, lut_in0}, {26'd0, prev_lut} + 32'd1);
                prev_busy = busy0;
                prev_lut  = lut_in0;
                if (done0) begin
                    done_cnt0++;
                    done_cyc0 = cyc;
                    check("done_busy0", {31'd0, busy0}, 32'd0);
                end
            end
        end
    end

    // Monitor / scoreboard for instance 1, including per-code hold length
    initial begin
        logic [7:0] e;
        logic [5:0] prev_lut;
        bit         prev_busy = 0;
        int         hold = 0;
        prev_lut = '0;
        forever begin
            @(negedge clk); #2;
            if (!rst_n) begin
                prev_busy = 0;
            end else begin
                if (valid1 && ready1) begin
                    if (exp1.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_word1: got %0h, expected no word", data1);
                    end else begin
                        e = exp1.pop_front();
                        check("word1", {24'd0, data1}, {24'd0, e});
                    end
                end
                if (busy1 && !prev_busy) begin
                    hold = 1;
                end else if (busy1 && prev_busy) begin
                    if (lut_in1 == prev_lut) begin
                        hold++;
                    end else begin
                        check("lut_step1", {26'd0, lut_in1}, {26'd0, prev_lut} + 32'd1);
                        check("lut_hold1", hold, 32'd3);
                        hold = 1;
                    end
                end
                prev_busy = busy1;
                prev_lut  = lut_in1;
                if (done1) begin
                    done_cnt1++;
                    done_cyc1 = cyc;
                end
            end
        end
    end

    task automatic push_words0();
        logic [7:0] w [8];
        w = '{8'hA0, 8'h00, 8'hA0, 8'h00, 8'hA0, 8'h00, 8'hA0, 8'h00};
        for (int i = 0; i < 8; i++) exp0.push_back(w[i]);
    endtask

    task automatic pulse_start0();
        @(negedge clk);
        start0 = 1'b1;
        start_cyc0 = cyc + 1;
        @(negedge clk);
        start0 = 1'b0;
    endtask

    task automatic wait_done0(input int target, input int maxc);
        int n = 0;
        while (done_cnt0 < target && n < maxc) begin
            @(negedge clk); #3;
            n++;
        end
        check("done0_reached", {31'd0, done_cnt0 >= target}, 32'd1);
    endtask

    initial begin
        int n;
        int dc;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("rst_busy0", {31'd0, busy0}, 32'd0);
        check("rst_done0", {31'd0, done0}, 32'd0);
        check("rst_lut_in0", {26'd0, lut_in0}, 32'd0);
        check("rst_valid0", {31'd0, valid0}, 32'd0);
        check("rst_data0", {24'd0, data0}, 32'd0);
        check("rst_busy1", {31'd0, busy1}, 32'd0);
        check("rst_valid1", {31'd0, valid1}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 1: full sweep at m_ready=1
        ready0 = 1'b1;
        push_words0();
        pulse_start0();
        wait_done0(1, 200);
        check("cycles_start_done0", done_cyc0 - start_cyc0, 32'd67);
        check("queue_empty_t1", exp0.size(), 32'd0);
        repeat (3) @(negedge clk);
        check("done_once_t1", done_cnt0, 32'd1);

        // 2: random back-pressure, same words
        push_words0();
        pulse_start0();
        n = 0;
        while (done_cnt0 < 2 && n < 3000) begin
            @(negedge clk);
            ready0 = ($urandom_range(0, 9) < 3);
            #3;
            n++;
        end
        check("done0_reached_t2", {31'd0, done_cnt0 >= 2}, 32'd1);
        @(negedge clk);
        ready0 = 1'b1;
        repeat (3) @(negedge clk);
        check("queue_empty_t2", exp0.size(), 32'd0);

        // 3: LUT_LAT=2 with parity neuron
        for (int w = 0; w < 8; w++) begin
            logic [7:0] v;
            v = '0;
            for (int b = 0; b < 8; b++) begin
                logic [5:0] code;
                code = 6'(w * 8 + b);
                v[b] = ^code;
            end
            exp1.push_back(v);
        end
        @(negedge clk);
        start1 = 1'b1;
        start_cyc1 = cyc + 1;
        @(negedge clk);
        start1 = 1'b0;
        n = 0;
        while (done_cnt1 < 1 && n < 400) begin
            @(negedge clk); #3;
            n++;
        end
        check("done1_reached", {31'd0, done_cnt1 >= 1}, 32'd1);
        check("cycles_start_done1", done_cyc1 - start_cyc1, 32'd195);
        check("queue_empty_t3", exp1.size(), 32'd0);

        // 4: abort the cycle after the third word is accepted
        exp0.push_back(8'hA0);
        exp0.push_back(8'h00);
        exp0.push_back(8'hA0);
        dc = done_cnt0;
        n = acc0;
        pulse_start0();
        while (acc0 < n + 3 && cyc < start_cyc0 + 200) begin
            @(negedge clk); #3;
        end
        check("three_words_t4", acc0 - n, 32'd3);
        @(negedge clk);
        abort0 = 1'b1;
        @(negedge clk);
        abort0 = 1'b0;
        #1;
        check("abort_valid0", {31'd0, valid0}, 32'd0);
        check("abort_busy0", {31'd0, busy0}, 32'd0);
        repeat (20) @(negedge clk);
        check("abort_no_done0", done_cnt0, dc);
        check("queue_empty_t4", exp0.size(), 32'd0);
        push_words0();
        pulse_start0();
        wait_done0(dc + 1, 200);
        check("queue_empty_t4b", exp0.size(), 32'd0);

        // 5: start while busy, then start+abort in IDLE
        dc = done_cnt0;
        push_words0();
        pulse_start0();
        repeat (20) @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        wait_done0(dc + 1, 200);
        repeat (30) @(negedge clk);
        #1;
        check("no_restart_done0", done_cnt0, dc + 1);
        check("no_restart_busy0", {31'd0, busy0}, 32'd0);
        check("queue_empty_t5", exp0.size(), 32'd0);
        @(negedge clk);
        start0 = 1'b1;
        abort0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        abort0 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("start_abort_busy0", {31'd0, busy0}, 32'd0);
            check("start_abort_valid0", {31'd0, valid0}, 32'd0);
            @(negedge clk);
        end

        // 6: asynchronous reset while a word is stalled on the port
        dc = done_cnt0;
        ready0 = 1'b0;
        pulse_start0();
        n = 0;
        while (!valid0 && n < 100) begin
            @(negedge clk); #3;
            n++;
        end
        check("valid_before_reset", {31'd0, valid0}, 32'd1);
        repeat (3) @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_busy0", {31'd0, busy0}, 32'd0);
        check("arst_done0", {31'd0, done0}, 32'd0);
        check("arst_lut_in0", {26'd0, lut_in0}, 32'd0);
        check("arst_valid0", {31'd0, valid0}, 32'd0);
        check("arst_data0", {24'd0, data0}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ready0 = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("post_rst_busy0", {31'd0, busy0}, 32'd0);
        check("post_rst_lut_in0", {26'd0, lut_in0}, 32'd0);
        check("post_rst_no_done0", done_cnt0, dc);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
